// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared key codes, scan/FSM enums and matrix-to-code mapping for the keypad scanner
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;
  localparam logic [3:0] KEY_NONE = 4'hF;

  typedef enum logic [1:0] {
    SCAN_NONE,
    SCAN_KEY,
    SCAN_MULTI
  } scan_res_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONFIRM,
    ST_HELD
  } state_t;

  // Rows 0-2 hold digits 1-9 in reading order; row 3 is "*", "0", "#".
  function automatic logic [3:0] key_code_of(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      unique case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

  function automatic logic [9:0] digit_onehot(input logic [3:0] code);
    logic [9:0] vec;
    vec = '0;
    if (code <= 4'd9) begin
      vec = 10'd1 << code;
    end
    return vec;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// rtl/keypad_if.sv - keypad digit/strobe interface between the scanner (master) and the controller (slave)
interface keypad_if;
  import keypad_pkg::*;

  logic [9:0] keypad;
  logic [3:0] key_code;
  logic       key_valid;
  logic       lock;

  modport master (
    output keypad,
    output key_code,
    output key_valid,
    input  lock
  );

  modport slave (
    input  keypad,
    input  key_code,
    input  key_valid,
    output lock
  );

endinterface

// File: rtl/keypad_row_driver.sv
// rtl/keypad_row_driver.sv - row prescaler/rotation, column synchronizer and per-scan 12-bit snapshot capture
module keypad_row_driver #(
  parameter int CLK_DIV = 1000
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [2:0]  col_n,
  output logic [3:0]  row_n,
  output logic [11:0] snapshot,
  output logic        scan_done
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [2:0]    col_meta;
  logic [2:0]    col_sync;
  logic [PW-1:0] prescale;
  logic [1:0]    row;
  logic          row_end;

  assign row_end = (prescale == PW'(CLK_DIV - 1));
  assign row_n   = ~(4'b0001 << row);

  // Snapshot bit (row*3 + col) is high when that key is down.
  always_ff @(posedge clock) begin
    if (clear) begin
      col_meta  <= 3'b111;
      col_sync  <= 3'b111;
      prescale  <= '0;
      row       <= 2'd0;
      snapshot  <= '0;
      scan_done <= 1'b0;
    end else begin
      col_meta  <= col_n;
      col_sync  <= col_meta;
      scan_done <= row_end && (row == 2'd3);
      if (row_end) begin
        prescale <= '0;
        row      <= row + 2'd1;
        unique case (row)
          2'd0:    snapshot[2:0]  <= ~col_sync;
          2'd1:    snapshot[5:3]  <= ~col_sync;
          2'd2:    snapshot[8:6]  <= ~col_sync;
          default: snapshot[11:9] <= ~col_sync;
        endcase
      end else begin
        prescale <= prescale + PW'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 keypad scanner top with debounce FSM; auto-repeat under KEYPAD_REPEAT_EN
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_DIV        = 1000,
  parameter int DEBOUNCE_SCANS = 3
`ifdef KEYPAD_REPEAT_EN
  , parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
`endif
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  keypad_if.master   kp
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [11:0]   snapshot;
  logic          scan_done;
  scan_res_t     scan_res;
  logic [3:0]    scan_code;
  logic          same_key;
  logic          accept;

  state_t        state, state_n;
  logic [3:0]    cand, cand_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] rel_cnt, rel_cnt_n;
  logic [9:0]    keypad_q, keypad_n;
  logic [3:0]    code_q, code_n;
  logic          valid_q, valid_n;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(RMAX + 1);

  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic          rpt_phase, rpt_phase_n;
  logic          armed, armed_n;
`endif

  keypad_row_driver #(
    .CLK_DIV (CLK_DIV)
  ) u_row_driver (
    .clock     (clock),
    .clear     (clear),
    .col_n     (col_n),
    .row_n     (row_n),
    .snapshot  (snapshot),
    .scan_done (scan_done)
  );

  always_comb begin : scan_eval
    logic [3:0] ones;
    ones      = '0;
    scan_code = KEY_NONE;
    for (int i = 0; i < 12; i++) begin
      if (snapshot[i]) begin
        ones      = ones + 4'd1;
        scan_code = key_code_of(2'(i / 3), 2'(i % 3));
      end
    end
    if (ones == 4'd0) begin
      scan_res = SCAN_NONE;
    end else if (ones == 4'd1) begin
      scan_res = SCAN_KEY;
    end else begin
      scan_res = SCAN_MULTI;
    end
  end

  assign same_key = (scan_res == SCAN_KEY) && (scan_code == cand);

  always_comb begin
    state_n   = state;
    cand_n    = cand;
    cnt_n     = cnt;
    rel_cnt_n = rel_cnt;
    keypad_n  = keypad_q;
    code_n    = code_q;
    valid_n   = 1'b0;
    accept    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    hold_cnt_n  = hold_cnt;
    rpt_phase_n = rpt_phase;
    armed_n     = armed;
`endif
    if (scan_done) begin
      unique case (state)
        ST_IDLE: begin
          if (scan_res == SCAN_KEY) begin
            cand_n = scan_code;
            cnt_n  = CW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              accept = 1'b1;
            end else begin
              state_n = ST_CONFIRM;
            end
          end
        end
        ST_CONFIRM: begin
          if (same_key) begin
            cnt_n = cnt + CW'(1);
            if (cnt_n == CW'(DEBOUNCE_SCANS)) begin
              accept = 1'b1;
            end
          end else if (scan_res == SCAN_KEY) begin
            cand_n = scan_code;
            cnt_n  = CW'(1);
          end else begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end
        end
        ST_HELD: begin
          if (same_key) begin
            rel_cnt_n = '0;
`ifdef KEYPAD_REPEAT_EN
            // Repeats only follow a press that was strobed when accepted.
            if (armed && !kp.lock) begin
              hold_cnt_n = hold_cnt + HW'(1);
              if (hold_cnt_n == (rpt_phase ? HW'(REPEAT_PERIOD) : HW'(REPEAT_DELAY))) begin
                valid_n     = 1'b1;
                hold_cnt_n  = '0;
                rpt_phase_n = 1'b1;
              end
            end
`endif
          end else begin
            rel_cnt_n = rel_cnt + CW'(1);
            if (rel_cnt_n == CW'(DEBOUNCE_SCANS)) begin
              keypad_n  = '0;
              state_n   = ST_IDLE;
              rel_cnt_n = '0;
`ifdef KEYPAD_REPEAT_EN
              armed_n   = 1'b0;
`endif
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase

      if (accept) begin
        state_n   = ST_HELD;
        cnt_n     = '0;
        rel_cnt_n = '0;
        if (!kp.lock) begin
          valid_n  = 1'b1;
          code_n   = cand_n;
          keypad_n = digit_onehot(cand_n);
        end else begin
          keypad_n = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        hold_cnt_n  = '0;
        rpt_phase_n = 1'b0;
        armed_n     = !kp.lock;
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= ST_IDLE;
      cand     <= KEY_NONE;
      cnt      <= '0;
      rel_cnt  <= '0;
      keypad_q <= '0;
      code_q   <= KEY_NONE;
      valid_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      hold_cnt  <= '0;
      rpt_phase <= 1'b0;
      armed     <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cand     <= cand_n;
      cnt      <= cnt_n;
      rel_cnt  <= rel_cnt_n;
      keypad_q <= keypad_n;
      code_q   <= code_n;
      valid_q  <= valid_n;
`ifdef KEYPAD_REPEAT_EN
      hold_cnt  <= hold_cnt_n;
      rpt_phase <= rpt_phase_n;
      armed     <= armed_n;
`endif
    end
  end

  assign kp.keypad    = keypad_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner (CLK_DIV=4, DEBOUNCE_SCANS=3)
module tb_keypad_scanner;

  localparam int CLK_DIV        = 4;
  localparam int DEBOUNCE_SCANS = 3;

  localparam int K1    = 0;
  localparam int K2    = 1;
  localparam int K3    = 2;
  localparam int K5    = 4;
  localparam int K7    = 6;
  localparam int K9    = 8;
  localparam int KSTAR = 9;
  localparam int K0    = 10;

  logic        clock = 1'b0;
  logic        clear;
  logic [2:0]  col_n;
  logic [3:0]  row_n;
  logic [11:0] held;

  int          passes     = 0;
  int          fails      = 0;
  int          checks     = 0;
  int          strobes    = 0;
  int          consec_err = 0;
  int          onehot_err = 0;
  int          base;
  logic [3:0]  last_code  = 4'hF;
  logic        prev_valid = 1'b0;

  keypad_if kp ();

  keypad_scanner #(
    .CLK_DIV        (CLK_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
`ifdef KEYPAD_REPEAT_EN
    , .REPEAT_DELAY  (4),
    .REPEAT_PERIOD (2)
`endif
  ) dut (
    .clock (clock),
    .clear (clear),
    .col_n (col_n),
    .row_n (row_n),
    .kp    (kp)
  );

  always #5 clock = ~clock;

  // Membrane model: a held key pulls its column low while its row is driven.
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++) begin
      if (!row_n[r]) begin
        for (int c = 0; c < 3; c++) begin
          if (held[r*3+c]) col_n[c] = 1'b0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (kp.key_valid) begin
      strobes   <= strobes + 1;
      last_code <= kp.key_code;
      if (prev_valid) consec_err <= consec_err + 1;
    end
    if (!$onehot0(kp.keypad)) onehot_err <= onehot_err + 1;
    prev_valid <= kp.key_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic scans(input int n);
    repeat (16 * n) @(negedge clock);
    #1;
  endtask

  initial begin
    held    = '0;
    clear   = 1'b1;
    kp.lock = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("reset_row_n", 32'(row_n), 32'h0000000e);
    check("reset_keypad", 32'(kp.keypad), 32'h0);
    check("reset_key_code", 32'(kp.key_code), 32'hf);
    check("reset_key_valid", 32'(kp.key_valid), 32'h0);
    clear = 1'b0;
    @(negedge clock); #1;
    check("rot_r0", 32'(row_n), 32'he);
    repeat (3) @(negedge clock); #1;
    check("rot_r1", 32'(row_n), 32'hd);
    repeat (4) @(negedge clock); #1;
    check("rot_r2", 32'(row_n), 32'hb);
    repeat (4) @(negedge clock); #1;
    check("rot_r3", 32'(row_n), 32'h7);
    repeat (4) @(negedge clock); #1;
    check("rot_wrap", 32'(row_n), 32'he);
    @(negedge clock); #1;
    check("idle_no_strobe", 32'(strobes), 32'd0);

    // Clean press of "5" for 5 scans, then release.
    base = strobes;
    held = 12'(1) << K5;
    scans(2);
    check("k5_two_scans_no_strobe", 32'(strobes - base), 32'd0);
    check("k5_two_scans_keypad", 32'(kp.keypad), 32'h0);
    scans(1);
    check("k5_strobe", 32'(strobes - base), 32'd1);
    check("k5_key_code", 32'(kp.key_code), 32'd5);
    check("k5_strobe_code", 32'(last_code), 32'd5);
    check("k5_keypad", 32'(kp.keypad), 32'h020);
    scans(2);
    check("k5_held_single_strobe", 32'(strobes - base), 32'd1);
    held = '0;
    scans(2);
    check("k5_release_pending", 32'(kp.keypad), 32'h020);
    scans(1);
    check("k5_released", 32'(kp.keypad), 32'h0);
    check("k5_code_kept", 32'(kp.key_code), 32'd5);

    // "7" bouncing on alternate scans.
    base = strobes;
    for (int i = 0; i < 8; i++) begin
      held = (i % 2 == 0) ? (12'(1) << K7) : 12'h000;
      scans(1);
    end
    check("bounce_no_strobe", 32'(strobes - base), 32'd0);
    check("bounce_keypad", 32'(kp.keypad), 32'h0);

    // "1" and "2" together.
    held = (12'(1) << K1) | (12'(1) << K2);
    scans(4);
    check("multi_no_strobe", 32'(strobes - base), 32'd0);
    check("multi_keypad", 32'(kp.keypad), 32'h0);
    held = '0;
    scans(1);

    // Star key.
    base = strobes;
    held = 12'(1) << KSTAR;
    scans(3);
    check("star_strobe", 32'(strobes - base), 32'd1);
    check("star_key_code", 32'(kp.key_code), 32'ha);
    check("star_keypad", 32'(kp.keypad), 32'h0);
    held = '0;
    scans(3);

    // "9" while locked, then unlocked.
    base    = strobes;
    kp.lock = 1'b1;
    held    = 12'(1) << K9;
    scans(4);
    check("lock_no_strobe", 32'(strobes - base), 32'd0);
    check("lock_keypad", 32'(kp.keypad), 32'h0);
    held = '0;
    scans(3);
    kp.lock = 1'b0;
    held    = 12'(1) << K9;
    scans(3);
    check("unlock_strobe", 32'(strobes - base), 32'd1);
    check("unlock_key_code", 32'(kp.key_code), 32'd9);
    check("unlock_keypad", 32'(kp.keypad), 32'h200);
    held = '0;
    scans(3);
    check("k9_released", 32'(kp.keypad), 32'h0);

    // Reset in the middle of debouncing "3".
    base = strobes;
    held = 12'(1) << K3;
    scans(2);
    clear = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("midrst_row_n", 32'(row_n), 32'he);
    check("midrst_key_code", 32'(kp.key_code), 32'hf);
    check("midrst_keypad", 32'(kp.keypad), 32'h0);
    check("midrst_key_valid", 32'(kp.key_valid), 32'h0);
    clear = 1'b0;
    @(negedge clock); #1;
    scans(2);
    check("midrst_no_early_strobe", 32'(strobes - base), 32'd0);
    scans(1);
    check("midrst_strobe", 32'(strobes - base), 32'd1);
    check("midrst_key_code_3", 32'(kp.key_code), 32'd3);
    check("midrst_keypad_3", 32'(kp.keypad), 32'h008);
    held = '0;
    scans(3);

    // "0" held for 12 scans.
    base = strobes;
    held = 12'(1) << K0;
    scans(3);
    check("k0_accept", 32'(strobes - base), 32'd1);
    check("k0_keypad_accept", 32'(kp.keypad), 32'h001);
    scans(9);
`ifdef KEYPAD_REPEAT_EN
    check("k0_repeat_strobes", 32'(strobes - base), 32'd4);
`else
    check("k0_single_strobe", 32'(strobes - base), 32'd1);
`endif
    check("k0_keypad_steady", 32'(kp.keypad), 32'h001);
    check("k0_last_code", 32'(last_code), 32'd0);
    held = '0;
    scans(3);
    check("k0_released", 32'(kp.keypad), 32'h0);

    check("no_back_to_back_strobes", 32'(consec_err), 32'd0);
    check("keypad_onehot0", 32'(onehot_err), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
